// File: rtl/hex_display_scanner.sv
// Multiplexed hex driver for common-anode 7-segment banks: holds a shadow value,
// scans one nibble per dwell period and swaps in new values only at frame boundaries.
module hex_display_scanner #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load,
    input  logic                    Enable,
    input  logic                    LzBlank,
    output logic [3:0]              Nibble,
    output logic [NUM_DIGITS-1:0]   DigitEn_n,
    output logic                    Blank,
    output logic                    FrameDone,
    output logic                    Pending
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = $clog2(REFRESH_CYCLES);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(REFRESH_CYCLES - 1);

    logic [4*NUM_DIGITS-1:0]      shadow;
    logic [NUM_DIGITS-1:0][3:0]   display;
    logic [IW-1:0]                idx;
    logic [DW-1:0]                dwell;
    logic                         frame_end;
    logic [NUM_DIGITS-1:0]        lz_mask;
    logic                         zero_above;

    // Enable is the IDLE/SCAN selector itself so dropping it darkens the bank immediately.
    assign frame_end = Enable && (idx == LAST_IDX) && (dwell == LAST_DWELL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            idx     <= '0;
            dwell   <= '0;
            Pending <= 1'b0;
        end else if (!Enable) begin
            idx     <= '0;
            dwell   <= '0;
            display <= shadow;
            Pending <= 1'b0;
            if (Load) shadow <= Value;
        end else begin
            if (frame_end) begin
                Pending <= 1'b0;
                if (Load) begin
                    display <= Value;
                    shadow  <= Value;
                end else begin
                    display <= shadow;
                end
            end else if (Load) begin
                shadow  <= Value;
                Pending <= 1'b1;
            end
            if (dwell == LAST_DWELL) begin
                dwell <= '0;
                idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // lz_mask[i]: every nibble from i upward is zero; digit 0 is never masked.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (display[i] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end

    assign Nibble    = display[idx];
    assign Blank     = !Enable || (dwell == '0) || (LzBlank && lz_mask[idx]);
    assign DigitEn_n = Blank ? '1 : ~(NUM_DIGITS'(1) << idx);
    assign FrameDone = frame_end;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (4 digits, 4-cycle dwell): a spec-level
// model pushes the expected outputs each cycle, a monitor pops and compares them.
module tb_hex_display_scanner;
    localparam int ND = 4;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = '0;
    logic          load = 1'b0, enable = 1'b0, lz_blank = 1'b0;
    logic [3:0]    nibble, digit_en_n;
    logic          blank, frame_done, pending;

    hex_display_scanner #(.NUM_DIGITS(ND), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .Value(value), .Load(load), .Enable(enable),
        .LzBlank(lz_blank), .Nibble(nibble), .DigitEn_n(digit_en_n), .Blank(blank),
        .FrameDone(frame_done), .Pending(pending));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] nib;
        logic [3:0] den;
        logic       blk;
        logic       fd;
        logic       pnd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0, bad = 0;

    logic [15:0] m_shadow, m_display;
    int          m_idx, m_dwell;
    logic        m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void m_reset();
        m_shadow = '0; m_display = '0; m_idx = 0; m_dwell = 0; m_pend = 1'b0;
    endfunction

    // Expected outputs for the current model state under the current inputs.
    function automatic exp_t m_expect(input logic en, input logic lz);
        exp_t r;
        logic lead_zero;
        lead_zero = (m_idx > 0) && ((m_display >> (4 * m_idx)) == 16'h0);
        r.nib = 4'((m_display >> (4 * m_idx)) & 16'hF);
        r.blk = !en || (m_dwell == 0) || (lz && lead_zero);
        r.den = r.blk ? 4'hF : 4'(~(1 << m_idx));
        r.fd  = en && (m_idx == ND - 1) && (m_dwell == RC - 1);
        r.pnd = m_pend;
        return r;
    endfunction

    function automatic void m_step(input logic en, input logic ld, input logic [15:0] v);
        logic boundary;
        if (!en) begin
            m_display = m_shadow;
            if (ld) m_shadow = v;
            m_idx = 0; m_dwell = 0; m_pend = 1'b0;
            return;
        end
        boundary = (m_idx == ND - 1) && (m_dwell == RC - 1);
        if (boundary) begin
            m_display = ld ? v : m_shadow;
            if (ld) m_shadow = v;
            m_pend = 1'b0;
        end else if (ld) begin
            m_shadow = v;
            m_pend = 1'b1;
        end
        m_dwell = m_dwell + 1;
        if (m_dwell == RC) begin
            m_dwell = 0;
            m_idx = (m_idx + 1) % ND;
        end
    endfunction

    task automatic cyc(input logic en, input logic ld, input logic [15:0] v, input logic lz);
        @(negedge clk);
        enable = en; load = ld; value = v; lz_blank = lz;
        q.push_back(m_expect(en, lz));
        m_step(en, ld, v);
    endtask

    task automatic run(input int n, input logic lz);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 16'h0, lz);
    endtask

    task automatic run_until(input int i, input int d, input logic lz);
        for (int k = 0; k < 64; k++) begin
            if (m_idx == i && m_dwell == d) return;
            cyc(1'b1, 1'b0, 16'h0, lz);
        end
        chk("run_until_timeout", 32'(m_idx * 16 + m_dwell), 32'(i * 16 + d));
    endtask

    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("nibble", 32'(nibble), 32'(e.nib));
            chk("digit_en_n", 32'(digit_en_n), 32'(e.den));
            chk("blank", 32'(blank), 32'(e.blk));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("pending", 32'(pending), 32'(e.pnd));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_nibble"}, 32'(nibble), 32'h0);
        chk({tag, "_digit_en_n"}, 32'(digit_en_n), 32'hF);
        chk({tag, "_blank"}, 32'(blank), 32'h1);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_pending"}, 32'(pending), 32'h0);
    endtask

    initial begin
        m_reset();
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // load while idle, then scan 1234
        cyc(1'b0, 1'b1, 16'h1234, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        run(40, 1'b0);

        // mid-frame load at idx 1 stays pending until the boundary
        run_until(1, 1, 1'b0);
        cyc(1'b1, 1'b1, 16'hBEEF, 1'b0);
        run(24, 1'b0);

        // back-to-back loads: last one wins
        run_until(2, 0, 1'b0);
        cyc(1'b1, 1'b1, 16'h1111, 1'b0);
        cyc(1'b1, 1'b1, 16'h2222, 1'b0);
        run(20, 1'b0);

        // load coincident with the frame boundary
        run_until(3, 3, 1'b0);
        cyc(1'b1, 1'b1, 16'hA5A5, 1'b0);
        run(18, 1'b0);

        // leading-zero blanking
        run_until(3, 3, 1'b1);
        cyc(1'b1, 1'b1, 16'h0070, 1'b1);
        run(18, 1'b1);
        run_until(3, 3, 1'b1);
        cyc(1'b1, 1'b1, 16'h0000, 1'b1);
        run(18, 1'b1);
        run(6, 1'b0);

        // drop enable mid-dwell, then re-enable
        run_until(3, 3, 1'b0);
        cyc(1'b1, 1'b1, 16'h9C3D, 1'b0);
        run_until(2, 2, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
        run(20, 1'b0);

        // random traffic
        for (int k = 0; k < 150; k++)
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                16'($urandom), 1'($urandom_range(0, 1)));

        // async reset mid-dwell with a pending value and nonzero display
        run_until(3, 3, 1'b0);
        cyc(1'b1, 1'b1, 16'h1235, 1'b0);
        run_until(1, 1, 1'b0);
        cyc(1'b1, 1'b1, 16'hBEEF, 1'b0);
        run(1, 1'b0);
        chk("pre_reset_pending", 32'(m_pend), 32'h1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        enable = 1'b0; load = 1'b0;
        rst_n = 1'b1;
        m_reset();
        run(20, 1'b0);

        @(negedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
